// File: rtl/output_port_if.sv
// Flit types shared by the router ports, and the crossbar/link/credit bundle
// seen by output_port.
package output_port_pkg;
  localparam int VC_ID_W = 4;
  localparam int DATA_W  = 8;

  typedef enum logic [1:0] {
    HEAD     = 2'd0,
    BODY     = 2'd1,
    TAIL     = 2'd2,
    HEADTAIL = 2'd3
  } flit_label_t;

  typedef struct packed {
    flit_label_t          flit_label;
    logic [VC_ID_W-1:0]   vc_id;
    logic [DATA_W-1:0]    data;
  } flit_t;
endpackage

interface output_port_if #(parameter int VC_NUM = 2);
  localparam int VCW = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;

  logic                      valid_i;
  output_port_pkg::flit_t    flit_i;
  logic                      ready_o;
  logic                      valid_o;
  output_port_pkg::flit_t    flit_o;
  logic                      credit_valid_i;
  logic [VCW-1:0]            credit_vc_i;
  logic [VC_NUM-1:0]         credit_avail_o;
  logic [VC_NUM-1:0]         vc_idle_o;
  logic                      err_o;

  modport master (
    output valid_i, flit_i, credit_valid_i, credit_vc_i,
    input  ready_o, valid_o, flit_o, credit_avail_o, vc_idle_o, err_o
  );

  modport slave (
    input  valid_i, flit_i, credit_valid_i, credit_vc_i,
    output ready_o, valid_o, flit_o, credit_avail_o, vc_idle_o, err_o
  );
endinterface

// File: rtl/output_port.sv
// Router output stage: staging FIFO onto the inter-router link, with
// per-VC credit counters, packet ownership tracking and a sticky error flag.
module output_port
  import output_port_pkg::*;
#(
  parameter int VC_NUM      = 2,
  parameter int BUFFER_SIZE = 8,
  parameter int FIFO_DEPTH  = 2
) (
  input  logic          clk,
  input  logic          rst,
  output_port_if.slave  port
);

  localparam int VCW = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int CW  = $clog2(BUFFER_SIZE + 1);
  localparam logic [CW-1:0] CMAX = CW'(BUFFER_SIZE);

  typedef enum logic {FREE, OWNED} own_t;

  flit_t            mem [FIFO_DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [PW:0]      count;

  logic [CW-1:0]    credit_q [VC_NUM];
  logic [CW-1:0]    credit_d [VC_NUM];
  own_t             own_q    [VC_NUM];
  own_t             own_d    [VC_NUM];
  logic             err_q, err_d;
  logic             valid_q;
  flit_t            flit_q;

  flit_t            head;
  logic [VCW-1:0]   head_vc;
  logic             full, empty, send, enq, drop;
  logic [VC_NUM-1:0] cred_inc, cred_dec;

  // A full FIFO still accepts a flit when the head leaves in the same cycle.
  always_comb begin
    full    = (count == (PW+1)'(FIFO_DEPTH));
    empty   = (count == '0);
    head    = mem[rd_ptr];
    head_vc = head.vc_id[VCW-1:0];
    send    = !empty && (credit_q[head_vc] != '0);
    enq     = port.valid_i && (!full || send);
    drop    = port.valid_i && full && !send;
    for (int unsigned v = 0; v < VC_NUM; v++) begin
      cred_inc[v] = port.credit_valid_i && (port.credit_vc_i == VCW'(v));
      cred_dec[v] = send && (head_vc == VCW'(v));
    end
  end

  always_comb begin
    err_d = err_q | drop;
    for (int unsigned v = 0; v < VC_NUM; v++) begin
      credit_d[v] = credit_q[v];
      own_d[v]    = own_q[v];

      if (cred_inc[v] && !cred_dec[v]) begin
        if (credit_q[v] == CMAX) err_d = 1'b1;
        else                     credit_d[v] = credit_q[v] + 1'b1;
      end else if (cred_dec[v] && !cred_inc[v]) begin
        credit_d[v] = credit_q[v] - 1'b1;
      end

      if (cred_dec[v]) begin
        unique case (own_q[v])
          FREE: begin
            if (head.flit_label == HEAD)
              own_d[v] = OWNED;
            else if (head.flit_label == BODY || head.flit_label == TAIL)
              err_d = 1'b1;
          end
          OWNED: begin
            if (head.flit_label == TAIL)
              own_d[v] = FREE;
            else if (head.flit_label == HEAD)
              err_d = 1'b1;
          end
          default: own_d[v] = own_q[v];
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (enq) mem[wr_ptr] <= port.flit_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      valid_q <= 1'b0;
      flit_q  <= '0;
      err_q   <= 1'b0;
      for (int unsigned v = 0; v < VC_NUM; v++) begin
        credit_q[v] <= CMAX;
        own_q[v]    <= FREE;
      end
    end else begin
      if (enq)  wr_ptr <= wr_ptr + 1'b1;
      if (send) rd_ptr <= rd_ptr + 1'b1;
      case ({enq, send})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      valid_q <= send;
      if (send) flit_q <= head;
      err_q   <= err_d;
      for (int unsigned v = 0; v < VC_NUM; v++) begin
        credit_q[v] <= credit_d[v];
        own_q[v]    <= own_d[v];
      end
    end
  end

  always_comb begin
    port.ready_o        = !full;
    port.valid_o        = valid_q;
    port.flit_o         = flit_q;
    port.err_o          = err_q;
    port.credit_avail_o = '0;
    port.vc_idle_o      = '0;
    for (int unsigned v = 0; v < VC_NUM; v++) begin
      port.credit_avail_o[v] = (credit_q[v] != '0);
      port.vc_idle_o[v]      = (own_q[v] == FREE) && (credit_q[v] == CMAX);
    end
  end

endmodule

// File: tb/tb_output_port.sv
// Scoreboard bench for output_port: accepted flits are queued and matched
// in order against the link; status and timing are checked at fixed points.
module tb_output_port;
  import output_port_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  output_port_if #(.VC_NUM(2)) bus ();

  output_port #(
    .VC_NUM      (2),
    .BUFFER_SIZE (8),
    .FIFO_DEPTH  (2)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .port (bus)
  );

  int    checks   = 0;
  int    failures = 0;
  int    sends    = 0;
  int    s0;
  flit_t exp_q [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input flit_label_t l, input int vc, input int d);
    flit_t f;
    f.flit_label = l;
    f.vc_id      = VC_ID_W'(vc);
    f.data       = DATA_W'(d);
    bus.valid_i  = 1'b1;
    bus.flit_i   = f;
    if (bus.ready_o) exp_q.push_back(f);
    cyc();
    bus.valid_i  = 1'b0;
  endtask

  task automatic credit(input int vc);
    bus.credit_valid_i = 1'b1;
    bus.credit_vc_i    = 1'(vc);
    cyc();
    bus.credit_valid_i = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
    exp_q.delete();
  endtask

  always @(negedge clk) begin
    if (!rst && bus.valid_o) begin
      sends++;
      check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        flit_t e;
        e = exp_q.pop_front();
        check("flit_o", bus.flit_o, e);
      end
    end
  end

  initial begin
    bus.valid_i        = 1'b0;
    bus.flit_i         = '0;
    bus.credit_valid_i = 1'b0;
    bus.credit_vc_i    = '0;

    do_reset();
    check("rst_valid",  bus.valid_o, 0);
    check("rst_ready",  bus.ready_o, 1);
    check("rst_avail",  bus.credit_avail_o, 2'b11);
    check("rst_idle",   bus.vc_idle_o, 2'b11);
    check("rst_err",    bus.err_o, 0);
    check("rst_flit",   bus.flit_o, 0);

    // single HEADTAIL on VC1: one-cycle latency, idle restored by credit
    put(HEADTAIL, 1, 8'h11);
    check("lat_edge0", bus.valid_o, 0);
    cyc();
    check("lat_edge1", bus.valid_o, 1);
    check("single_idle", bus.vc_idle_o, 2'b01);
    check("single_avail", bus.credit_avail_o, 2'b11);
    credit(1);
    check("single_idle_back", bus.vc_idle_o, 2'b11);
    check("single_err", bus.err_o, 0);

    // ownership on VC1
    put(HEAD, 1, 8'h21);
    put(BODY, 1, 8'h22);
    put(TAIL, 1, 8'h23);
    check("own_idle_mid", bus.vc_idle_o, 2'b01);
    cyc();
    cyc();
    check("own_idle_drained", bus.vc_idle_o, 2'b01);
    check("own_err_clean", bus.err_o, 0);
    credit(1);
    credit(1);
    check("own_idle_partial", bus.vc_idle_o, 2'b01);
    credit(1);
    check("own_idle_back", bus.vc_idle_o, 2'b11);
    put(BODY, 1, 8'h24);
    cyc();
    cyc();
    check("own_body_free_err", bus.err_o, 1);
    credit(1);
    check("own_state_free", bus.vc_idle_o, 2'b11);

    do_reset();
    check("rst2_err",   bus.err_o, 0);
    check("rst2_idle",  bus.vc_idle_o, 2'b11);
    check("rst2_ready", bus.ready_o, 1);

    // credit exhaustion, head-of-line blocking, drop while full
    s0 = sends;
    put(HEAD, 0, 8'h30);
    for (int k = 1; k <= 8; k++) put(BODY, 0, 8'h30 + k);
    put(HEADTAIL, 1, 8'h40);
    check("exh_ready_full", bus.ready_o, 0);
    check("exh_avail", bus.credit_avail_o, 2'b10);
    check("exh_valid_held", bus.valid_o, 0);
    check("exh_sent8", sends - s0, 8);
    put(BODY, 0, 8'h50);
    check("drop_err", bus.err_o, 1);
    check("hol_blocked", bus.valid_o, 0);
    credit(0);
    check("cred_edge_t", bus.valid_o, 0);
    cyc();
    check("cred_edge_t2", bus.valid_o, 1);
    check("ninth_data", bus.flit_o.data, 8'h38);
    cyc();
    check("hol_vc1_next", bus.valid_o, 1);
    check("hol_vc1_id", bus.flit_o.vc_id, 1);
    cyc();
    check("exh_idle_link", bus.valid_o, 0);
    check("exh_sent10", sends - s0, 10);
    check("exh_ready_back", bus.ready_o, 1);
    check("exh_avail_end", bus.credit_avail_o, 2'b10);

    do_reset();
    // send and return on VC0 in the same cycle: counter stays at max, no error
    put(HEADTAIL, 0, 8'h60);
    credit(0);
    check("sim_valid", bus.valid_o, 1);
    check("sim_idle", bus.vc_idle_o, 2'b11);
    check("sim_err", bus.err_o, 0);
    credit(1);
    check("ovf_err", bus.err_o, 1);
    check("ovf_idle", bus.vc_idle_o, 2'b11);
    check("ovf_avail", bus.credit_avail_o, 2'b11);
    cyc();
    check("sb_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
